// File: rtl/alu181_pkg.sv
// Shared types and constants for the nibble-serial 74181 word ALU.
package alu181_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Select codes; S_XOR shares its encoding with S_SUB and is meant for M = 1.
    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic [3:0] S_SUB = 4'b0110;
    localparam logic [3:0] S_XOR = 4'b0110;

    localparam logic M_ARITH = 1'b0;
    localparam logic M_LOGIC = 1'b1;

endpackage

// File: rtl/alu181_slice.sv
// Combinational 4-bit 74181 slice, active-high data, active-low carries.
module alu181_slice
    import alu181_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic [3:0]          s,
    input  logic                m,
    input  logic                cn_b,
    output logic [NIBBLE_W-1:0] f,
    output logic                aeb,
    output logic                x,
    output logic                y,
    output logic                cn4_b
);

    logic [NIBBLE_W-1:0] p_c;
    logic [NIBBLE_W-1:0] g_c;
    logic [NIBBLE_W-1:0] half_c;
    logic [NIBBLE_W:0]   c_c;

    // Per-bit propagate/generate selected by S; G always implies P.
    always_comb begin
        p_c    = a | (b & {NIBBLE_W{s[0]}}) | (~b & {NIBBLE_W{s[1]}});
        g_c    = (a & b & {NIBBLE_W{s[3]}}) | (a & ~b & {NIBBLE_W{s[2]}});
        half_c = p_c & ~g_c;
    end

    // Ripple carry, internally active-high.
    always_comb begin
        c_c    = '0;
        c_c[0] = ~cn_b;
        for (int i = 0; i < int'(NIBBLE_W); i++) begin
            c_c[i+1] = g_c[i] | (p_c[i] & c_c[i]);
        end
    end

    always_comb begin
        f     = m ? ~half_c : (half_c ^ c_c[NIBBLE_W-1:0]);
        aeb   = &f;
        cn4_b = ~c_c[NIBBLE_W];
        x     = ~(&p_c);
        y     = ~(g_c[3] | (p_c[3] & g_c[2]) | (p_c[3] & p_c[2] & g_c[1])
                  | (p_c[3] & p_c[2] & p_c[1] & g_c[0]));
    end

endmodule

// File: rtl/alu181_word_sequencer.sv
// Word-wide ALU that runs one 74181 slice over the operands a nibble per clock,
// chaining CN4b back into CNb through a carry register.
module alu181_word_sequencer
    import alu181_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a_in,
    input  logic [4*NIBBLES-1:0]   b_in,
    input  logic [3:0]             s_in,
    input  logic                   m_in,
    input  logic                   cn_b_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   f_out,
    output logic                   cn_b_out,
    output logic                   aeb_out
);

    localparam int unsigned W     = NIBBLE_W * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [3:0]       s_q, s_d;
    logic             m_q, m_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     res_q, res_d;
    logic             aeb_run_q, aeb_run_d;
    logic [W-1:0]     f_out_q, f_out_d;
    logic             cn_b_out_q, cn_b_out_d;
    logic             aeb_out_q, aeb_out_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [NIBBLE_W-1:0] slice_a_c;
    logic [NIBBLE_W-1:0] slice_b_c;
    logic [NIBBLE_W-1:0] slice_f_c;
    logic                slice_aeb_c;
    logic                slice_cn4_b_c;
    logic                unused_x;
    logic                unused_y;

    assign slice_a_c = a_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
    assign slice_b_c = b_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];

    alu181_slice u_slice (
        .a     (slice_a_c),
        .b     (slice_b_c),
        .s     (s_q),
        .m     (m_q),
        .cn_b  (carry_q),
        .f     (slice_f_c),
        .aeb   (slice_aeb_c),
        .x     (unused_x),
        .y     (unused_y),
        .cn4_b (slice_cn4_b_c)
    );

    // Next-state, datapath and output-register update.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        a_d        = a_q;
        b_d        = b_q;
        s_d        = s_q;
        m_d        = m_q;
        carry_d    = carry_q;
        res_d      = res_q;
        aeb_run_d  = aeb_run_q;
        f_out_d    = f_out_q;
        cn_b_out_d = cn_b_out_q;
        aeb_out_d  = aeb_out_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d       = a_in;
                    b_d       = b_in;
                    s_d       = s_in;
                    m_d       = m_in;
                    carry_d   = cn_b_in;
                    idx_d     = '0;
                    aeb_run_d = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d[int'(idx_q)*NIBBLE_W +: NIBBLE_W] = slice_f_c;
                carry_d   = slice_cn4_b_c;
                aeb_run_d = aeb_run_q & slice_aeb_c;
                idx_d     = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    idx_d      = '0;
                    f_out_d    = res_d;
                    cn_b_out_d = slice_cn4_b_c;
                    aeb_out_d  = aeb_run_d;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            m_q         <= 1'b0;
            carry_q     <= 1'b1;
            res_q       <= '0;
            aeb_run_q   <= 1'b0;
            f_out_q     <= '0;
            cn_b_out_q  <= 1'b1;
            aeb_out_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s_q         <= s_d;
            m_q         <= m_d;
            carry_q     <= carry_d;
            res_q       <= res_d;
            aeb_run_q   <= aeb_run_d;
            f_out_q     <= f_out_d;
            cn_b_out_q  <= cn_b_out_d;
            aeb_out_q   <= aeb_out_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign f_out     = f_out_q;
    assign cn_b_out  = cn_b_out_q;
    assign aeb_out   = aeb_out_q;

endmodule

// File: doc/alu181_word_sequencer.md
# alu181_word_sequencer

Multi-cycle 16-bit ALU built from a single 4-bit 74181-style slice. It sits on the other side of the slice's carry interface: it consumes the slice's active-low carry-out (CN4b) and feeds it back as the next nibble's carry-in (CNb), processing one nibble per clock. Operands and function select enter through a valid/ready request port, and the word result leaves through a valid/ready response port.

## Interface
- `NIBBLES`, default 4: number of 4-bit nibbles per word. Word width W = 4*NIBBLES.
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: high only in IDLE.
- `a_in` in W: operand A.
- `b_in` in W: operand B.
- `s_in` in 4: 74181 function select S[3:0].
- `m_in` in 1: mode. 1 = logic, 0 = arithmetic.
- `cn_b_in` in 1: active-low carry-in to nibble 0.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `f_out` out W: result word.
- `cn_b_out` out 1: active-low carry-out of the top nibble.
- `aeb_out` out 1: high when all bits of `f_out` are 1 (the 74181 A=B output, word-wide).

## Operation
- States:
  - IDLE: `in_ready` = 1.
  - RUN: nibble index `idx` runs from 0 to NIBBLES-1.
  - DONE: `out_valid` = 1.
- IDLE -> RUN on `in_valid` & `in_ready`.
  - Capture `a_in`, `b_in`, `s_in`, `m_in` and `cn_b_in` into internal registers.
  - Set `idx` = 0 and the carry register to `cn_b_in`.
  - Input-port changes after acceptance have no effect on the operation.
- RUN, each cycle:
  - Drive the slice with nibble `idx` of A and B, the captured S and M, and the carry register.
  - Write the slice's F into nibble `idx` of the result register.
  - Load the carry register from the slice's CN4b.
  - AND the slice's AEB into a running `aeb` flag; the flag is set to 1 on accept.
  - Increment `idx`.
- RUN -> DONE after the `idx` = NIBBLES-1 cycle.
  - `cn_b_out` takes the final CN4b.
  - `f_out` and `aeb_out` are complete.
- DONE -> IDLE on `out_ready`.
  - `f_out`, `cn_b_out` and `aeb_out` hold their values until the next result completes.
- Logic mode (M = 1):
  - The carry chain still runs.
  - `cn_b_out` reports whatever the slice produces; F does not depend on carry.
- Carry polarity follows 74181 active-high data: `cn_b` = 0 means carry. For subtraction, `cn_b_out` = 0 means no borrow.
- No wrap or overflow detection beyond `cn_b_out`. Arithmetic is modulo 2^W.

## Timing
- Reset values:
  - State = IDLE, so `in_ready` = 1 from the first cycle after reset.
  - `out_valid` = 0.
  - `f_out` = 0.
  - `cn_b_out` = 1.
  - `aeb_out` = 0.
  - `idx` = 0.
- Latency: accept at edge k. Nibbles are computed at edges k+1 through k+NIBBLES. `out_valid` is high after edge k+NIBBLES.
- Throughput: when `out_ready` is tied high, one operation every NIBBLES+2 cycles.
- `in_ready` and `out_valid` are decoded from registered state only. No combinational path from `in_valid` or `out_ready` to any output.
- `out_valid` held with `out_ready` = 0: result and flags stay stable indefinitely. A new `in_valid` is not accepted.
- `rst` during RUN or DONE: the operation is aborted. All outputs take their reset values at the next edge, and no partial result is ever flagged valid.
- `rst` together with `in_valid` in the same cycle: reset wins, and nothing is accepted.

## Structure
- Package `alu181_pkg` holds:
  - The state enum (IDLE, RUN, DONE).
  - The `NIBBLE_W` = 4 constant.
  - Named select constants: `S_ADD` = 4'b1001, `S_SUB` = 4'b0110, `S_XOR` = 4'b0110 with M = 1.
- One sub-module: `alu181_slice`, a purely combinational 4-bit 74181 slice.
  - Inputs: A, B, S, M, CNb.
  - Outputs: F, AEB, X, Y, CN4b.
  - X and Y are left unconnected in the sequencer.
- The sequencer contains only the FSM, the operand registers, the carry register, the result register and the flag register.

## Test plan
- ADD with carry-out: A = 0xFFFF, B = 0x0001, S = 1001, M = 0, `cn_b_in` = 1 -> after 4 RUN cycles, `f_out` = 0x0000, `cn_b_out` = 0, `aeb_out` = 0.
- SUB: A = 0x1234, B = 0x0234, S = 0110, M = 0, `cn_b_in` = 0 -> `f_out` = 0x1000, `cn_b_out` = 0 (no borrow).
- Equality compare: A = B = 0x5A5A, S = 0110, M = 0, `cn_b_in` = 1 -> `f_out` = 0xFFFF, `aeb_out` = 1. Repeat with B = 0x5A5B -> `aeb_out` = 0.
- Logic XOR: A = 0xF0F0, B = 0xFF00, S = 0110, M = 1 -> `f_out` = 0x0FF0. Toggle `cn_b_in` between runs -> `f_out` unchanged.
- Backpressure and operand isolation:
  - Hold `out_ready` = 0 for 10 cycles after `out_valid` -> outputs stable, `in_ready` = 0.
  - Change `a_in` mid-RUN -> no effect on the result.
  - Raise `out_ready` -> IDLE next cycle.
- Reset mid-RUN: assert `rst` at `idx` = 2 -> next cycle `out_valid` = 0, `f_out` = 0, `cn_b_out` = 1, `in_ready` = 1. A following ADD (0x0001 + 0x0001) gives 0x0002.
